// File: rtl/exe_decode_pipe_pkg.sv
// Shared encodings for the execute-stage decoder: micro-opcodes, immediate
// formats, branch functions and ALU control bundle.
package exe_decode_pipe_pkg;

  localparam int unsigned UOP_W      = 6;
  localparam int unsigned IMM_W      = 3;
  localparam int unsigned BR_W       = 3;
  localparam int unsigned ALU_FN_W   = 5;
  localparam int unsigned ALU_CTRL_W = ALU_FN_W + 1;

  typedef enum logic [UOP_W-1:0] {
    UOP_LUI, UOP_AUIPC, UOP_ADDI, UOP_SLTI, UOP_SLTIU, UOP_XORI, UOP_ORI,
    UOP_ANDI, UOP_SLLI, UOP_SRLI, UOP_SRAI, UOP_ADD, UOP_SUB, UOP_SLL,
    UOP_SLT, UOP_SLTU, UOP_XOR, UOP_SRL, UOP_SRA, UOP_OR, UOP_AND,
    UOP_JAL, UOP_JALR, UOP_BEQ, UOP_BNE, UOP_BLT, UOP_BGE, UOP_BLTU,
    UOP_BGEU, UOP_GREVI, UOP_ANDN, UOP_ORN, UOP_XNOR, UOP_MIN, UOP_MINU,
    UOP_MAX, UOP_MAXU, UOP_CBSXT, UOP_PACK
  } micro_opcode_t;

  typedef enum logic [IMM_W-1:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_t;

  typedef enum logic [BR_W-1:0] {
    BR_NONE, BR_JAL, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
  } br_func_t;

  typedef enum logic [ALU_FN_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_BREV, ALU_ANDN, ALU_ORN, ALU_XORN, ALU_MIN,
    ALU_MINU, ALU_MAX, ALU_MAXU, ALU_CLZ, ALU_CTZ, ALU_CPOP, ALU_SXTB,
    ALU_SXTH, ALU_ZXTH
  } alu_fn_t;

  typedef struct packed {
    alu_fn_t fn;
    logic    op2_imm;
  } alu_ctrl_sigs_t;

endpackage

// File: rtl/exe_decode_pipe.sv
// Multi-lane execute-stage decoder feeding a two-entry elastic buffer.
// Optional bitmanip decode is enabled by defining EXE_DEC_BITMANIP_EN.
module exe_decode_pipe
  import exe_decode_pipe_pkg::*;
#(
  parameter int unsigned LANES = 2,
  parameter int unsigned TAG_W = 6
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [LANES-1:0]                     in_lane_vld,
  input  logic [LANES-1:0][UOP_W-1:0]          in_uopcode,
  input  logic [LANES-1:0][19:0]               in_packed_imm,
  input  logic [LANES-1:0][IMM_W-1:0]          in_imm_type,
  input  logic [LANES-1:0][TAG_W-1:0]          in_tag,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [LANES-1:0]                     out_lane_vld,
  output logic [LANES-1:0][ALU_CTRL_W-1:0]     out_alu_ctrl,
  output logic [LANES-1:0][BR_W-1:0]           out_brfn,
  output logic [LANES-1:0][31:0]               out_imm,
  output logic [LANES-1:0]                     out_illegal,
  output logic [LANES-1:0][TAG_W-1:0]          out_tag
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  typedef struct packed {
    alu_ctrl_sigs_t alu;
    br_func_t       br;
    logic [31:0]    imm;
    logic           ill;
  } lane_t;

  typedef struct packed {
    logic [LANES-1:0]                 lane_vld;
    logic [LANES-1:0][ALU_CTRL_W-1:0] alu;
    logic [LANES-1:0][BR_W-1:0]       brfn;
    logic [LANES-1:0][31:0]           imm;
    logic [LANES-1:0]                 ill;
    logic [LANES-1:0][TAG_W-1:0]      tag;
  } grp_t;

  state_t r_state;
  logic   r_in_ready;
  grp_t   r_out;
  grp_t   r_skd;
  grp_t   w_dec;
  lane_t  w_lane [LANES];
  logic   w_acc;

  function automatic lane_t f_decode(input micro_opcode_t uop, input imm_type_t it,
                                     input logic [19:0] p);
    lane_t d;
    logic  s, u, j, b, i;
    d.alu = '{fn: ALU_ADD, op2_imm: 1'b1};
    d.br  = BR_NONE;
    d.ill = 1'b0;
    case (uop)
      UOP_LUI, UOP_ADDI, UOP_AUIPC, UOP_JAL, UOP_JALR,
      UOP_BEQ, UOP_BNE, UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU: begin end
      UOP_SLTI:  d.alu.fn = ALU_SLT;
      UOP_SLTIU: d.alu.fn = ALU_SLTU;
      UOP_XORI:  d.alu.fn = ALU_XOR;
      UOP_ORI:   d.alu.fn = ALU_OR;
      UOP_ANDI:  d.alu.fn = ALU_AND;
      UOP_SLLI:  d.alu.fn = ALU_SLL;
      UOP_SRLI:  d.alu.fn = ALU_SRL;
      UOP_SRAI:  d.alu.fn = ALU_SRA;
      UOP_ADD:   d.alu = '{fn: ALU_ADD,  op2_imm: 1'b0};
      UOP_SUB:   d.alu = '{fn: ALU_SUB,  op2_imm: 1'b0};
      UOP_SLL:   d.alu = '{fn: ALU_SLL,  op2_imm: 1'b0};
      UOP_SLT:   d.alu = '{fn: ALU_SLT,  op2_imm: 1'b0};
      UOP_SLTU:  d.alu = '{fn: ALU_SLTU, op2_imm: 1'b0};
      UOP_XOR:   d.alu = '{fn: ALU_XOR,  op2_imm: 1'b0};
      UOP_SRL:   d.alu = '{fn: ALU_SRL,  op2_imm: 1'b0};
      UOP_SRA:   d.alu = '{fn: ALU_SRA,  op2_imm: 1'b0};
      UOP_OR:    d.alu = '{fn: ALU_OR,   op2_imm: 1'b0};
      UOP_AND:   d.alu = '{fn: ALU_AND,  op2_imm: 1'b0};
`ifdef EXE_DEC_BITMANIP_EN
      UOP_GREVI: d.alu.fn = ALU_BREV;
      UOP_ANDN:  d.alu = '{fn: ALU_ANDN, op2_imm: 1'b0};
      UOP_ORN:   d.alu = '{fn: ALU_ORN,  op2_imm: 1'b0};
      UOP_XNOR:  d.alu = '{fn: ALU_XORN, op2_imm: 1'b0};
      UOP_MIN:   d.alu = '{fn: ALU_MIN,  op2_imm: 1'b0};
      UOP_MINU:  d.alu = '{fn: ALU_MINU, op2_imm: 1'b0};
      UOP_MAX:   d.alu = '{fn: ALU_MAX,  op2_imm: 1'b0};
      UOP_MAXU:  d.alu = '{fn: ALU_MAXU, op2_imm: 1'b0};
      // sub-function is the low three bits of shamt (packed[12:8])
      UOP_CBSXT: begin
        case (p[10:8])
          3'b000:  d.alu.fn = ALU_CLZ;
          3'b001:  d.alu.fn = ALU_CTZ;
          3'b010:  d.alu.fn = ALU_CPOP;
          3'b100:  d.alu.fn = ALU_SXTB;
          3'b101:  d.alu.fn = ALU_SXTH;
          default: d.ill    = 1'b1;
        endcase
      end
      UOP_PACK:  d.alu.fn = ALU_ZXTH;
`endif
      default:   d.ill = 1'b1;
    endcase

    case (uop)
      UOP_JAL, UOP_JALR: d.br = BR_JAL;
      UOP_BEQ:           d.br = BR_BEQ;
      UOP_BNE:           d.br = BR_BNE;
      UOP_BLT:           d.br = BR_BLT;
      UOP_BGE:           d.br = BR_BGE;
      UOP_BLTU:          d.br = BR_BLTU;
      UOP_BGEU:          d.br = BR_BGEU;
      default:           d.br = BR_NONE;
    endcase

    s = p[19];
    u = (it == IMM_U);
    j = (it == IMM_J);
    b = (it == IMM_B);
    i = (it == IMM_I);
    d.imm[31]    = s;
    d.imm[30:20] = u ? p[18:8] : {11{s}};
    d.imm[19:12] = (u | j) ? p[7:0] : {8{s}};
    d.imm[11]    = u ? 1'b0 : ((j | b) ? p[8] : s);
    d.imm[10:5]  = u ? '0 : p[18:13];
    d.imm[4:1]   = u ? '0 : p[12:9];
    d.imm[0]     = i ? p[8] : 1'b0;
    return d;
  endfunction

  always_comb begin
    w_dec          = '0;
    w_lane         = '{default: '0};
    w_dec.lane_vld = in_lane_vld;
    w_dec.tag      = in_tag;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_lane[l]     = f_decode(micro_opcode_t'(in_uopcode[l]), imm_type_t'(in_imm_type[l]),
                               in_packed_imm[l]);
      w_dec.alu[l]  = w_lane[l].alu;
      w_dec.brfn[l] = w_lane[l].br;
      w_dec.imm[l]  = w_lane[l].imm;
      w_dec.ill[l]  = w_lane[l].ill & in_lane_vld[l];
    end
  end

  assign w_acc = in_valid && r_in_ready;

  // in_ready is a registered copy of (next state != TWO), so out_ready never
  // reaches in_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_out      <= '0;
      r_skd      <= '0;
    end else if (flush) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_out   <= w_dec;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && !out_ready) begin
            r_skd      <= w_dec;
            r_state    <= ST_TWO;
            r_in_ready <= 1'b0;
          end else if (w_acc) begin
            r_out <= w_dec;
          end else if (out_ready) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_ready) begin
            r_out      <= r_skd;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = (r_state != ST_EMPTY);
  assign out_lane_vld = r_out.lane_vld;
  assign out_alu_ctrl = r_out.alu;
  assign out_brfn     = r_out.brfn;
  assign out_imm      = r_out.imm;
  assign out_illegal  = r_out.ill;
  assign out_tag      = r_out.tag;

endmodule

// File: tb/tb_exe_decode_pipe.sv
// Self-checking bench for exe_decode_pipe: directed decode table, buffer
// corner sequences and a randomized run against a queue-based reference.
module tb_exe_decode_pipe;
  import exe_decode_pipe_pkg::*;

  localparam int unsigned LANES = 4;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned GW    = LANES * (1 + ALU_CTRL_W + BR_W + 32 + 1 + TAG_W);

  logic clk = 1'b0;
  logic rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [LANES-1:0]                 in_lane_vld;
  logic [LANES-1:0][UOP_W-1:0]      in_uopcode;
  logic [LANES-1:0][19:0]           in_packed_imm;
  logic [LANES-1:0][IMM_W-1:0]      in_imm_type;
  logic [LANES-1:0][TAG_W-1:0]      in_tag;
  logic [LANES-1:0]                 out_lane_vld;
  logic [LANES-1:0][ALU_CTRL_W-1:0] out_alu_ctrl;
  logic [LANES-1:0][BR_W-1:0]       out_brfn;
  logic [LANES-1:0][31:0]           out_imm;
  logic [LANES-1:0]                 out_illegal;
  logic [LANES-1:0][TAG_W-1:0]      out_tag;

  int n_chk = 0;
  int n_err = 0;
  logic [GW-1:0] q_exp [$];

  always #5 clk = ~clk;

  exe_decode_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_uopcode(in_uopcode), .in_packed_imm(in_packed_imm),
    .in_imm_type(in_imm_type), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_vld(out_lane_vld), .out_alu_ctrl(out_alu_ctrl), .out_brfn(out_brfn),
    .out_imm(out_imm), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Immediate as the ISA formats it: sign-extended field concatenations.
  function automatic logic [31:0] m_imm(input logic [2:0] it, input logic [19:0] p);
    case (it)
      IMM_I:   return {{20{p[19]}}, p[19:8]};
      IMM_U:   return {p, 12'h000};
      IMM_B:   return {{19{p[19]}}, p[19], p[8], p[18:9], 1'b0};
      IMM_J:   return {{11{p[19]}}, p[19], p[7:0], p[8], p[18:9], 1'b0};
      default: return {{20{p[19]}}, p[19:9], 1'b0};
    endcase
  endfunction

  // Returns {fn, op2_imm, illegal}.
  function automatic logic [6:0] m_alu(input logic [5:0] op, input logic [19:0] p);
    logic [4:0] fn  = ALU_ADD;
    logic       imm = 1'b1;
    logic       ill = 1'b0;
    logic [4:0] cb_fn [8];
    logic [7:0] cb_ok;
    cb_fn = '{ALU_CLZ, ALU_CTZ, ALU_CPOP, ALU_ADD, ALU_SXTB, ALU_SXTH, ALU_ADD, ALU_ADD};
    cb_ok = 8'b0011_0111;
    case (op)
      UOP_LUI, UOP_ADDI, UOP_AUIPC, UOP_JAL, UOP_JALR, UOP_BEQ, UOP_BNE,
      UOP_BLT, UOP_BGE, UOP_BLTU, UOP_BGEU: begin end
      UOP_SLTI:  fn = ALU_SLT;
      UOP_SLTIU: fn = ALU_SLTU;
      UOP_XORI:  fn = ALU_XOR;
      UOP_ORI:   fn = ALU_OR;
      UOP_ANDI:  fn = ALU_AND;
      UOP_SLLI:  fn = ALU_SLL;
      UOP_SRLI:  fn = ALU_SRL;
      UOP_SRAI:  fn = ALU_SRA;
      UOP_ADD:   imm = 1'b0;
      UOP_SUB:   begin fn = ALU_SUB;  imm = 1'b0; end
      UOP_SLL:   begin fn = ALU_SLL;  imm = 1'b0; end
      UOP_SLT:   begin fn = ALU_SLT;  imm = 1'b0; end
      UOP_SLTU:  begin fn = ALU_SLTU; imm = 1'b0; end
      UOP_XOR:   begin fn = ALU_XOR;  imm = 1'b0; end
      UOP_SRL:   begin fn = ALU_SRL;  imm = 1'b0; end
      UOP_SRA:   begin fn = ALU_SRA;  imm = 1'b0; end
      UOP_OR:    begin fn = ALU_OR;   imm = 1'b0; end
      UOP_AND:   begin fn = ALU_AND;  imm = 1'b0; end
`ifdef EXE_DEC_BITMANIP_EN
      UOP_GREVI: fn = ALU_BREV;
      UOP_ANDN:  begin fn = ALU_ANDN; imm = 1'b0; end
      UOP_ORN:   begin fn = ALU_ORN;  imm = 1'b0; end
      UOP_XNOR:  begin fn = ALU_XORN; imm = 1'b0; end
      UOP_MIN:   begin fn = ALU_MIN;  imm = 1'b0; end
      UOP_MINU:  begin fn = ALU_MINU; imm = 1'b0; end
      UOP_MAX:   begin fn = ALU_MAX;  imm = 1'b0; end
      UOP_MAXU:  begin fn = ALU_MAXU; imm = 1'b0; end
      UOP_CBSXT: begin fn = cb_fn[p[10:8]]; ill = ~cb_ok[p[10:8]]; end
      UOP_PACK:  fn = ALU_ZXTH;
`endif
      default:   ill = 1'b1;
    endcase
    return {fn, imm, ill};
  endfunction

  function automatic logic [2:0] m_br(input logic [5:0] op);
    case (op)
      UOP_JAL, UOP_JALR: return BR_JAL;
      UOP_BEQ:  return BR_BEQ;
      UOP_BNE:  return BR_BNE;
      UOP_BLT:  return BR_BLT;
      UOP_BGE:  return BR_BGE;
      UOP_BLTU: return BR_BLTU;
      UOP_BGEU: return BR_BGEU;
      default:  return BR_NONE;
    endcase
  endfunction

  function automatic logic [GW-1:0] m_group();
    logic [LANES-1:0][ALU_CTRL_W-1:0] a;
    logic [LANES-1:0][BR_W-1:0]       br;
    logic [LANES-1:0][31:0]           im;
    logic [LANES-1:0]                 il;
    logic [6:0]                       r;
    for (int l = 0; l < LANES; l++) begin
      r     = m_alu(in_uopcode[l], in_packed_imm[l]);
      a[l]  = r[6:1];
      il[l] = r[0] & in_lane_vld[l];
      br[l] = m_br(in_uopcode[l]);
      im[l] = m_imm(in_imm_type[l], in_packed_imm[l]);
    end
    return {in_lane_vld, a, br, im, il, in_tag};
  endfunction

  function automatic logic [GW-1:0] act_group();
    return {out_lane_vld, out_alu_ctrl, out_brfn, out_imm, out_illegal, out_tag};
  endfunction

  typedef struct {
    string       name;
    logic [5:0]  uop;
    logic [2:0]  it;
    logic [19:0] p;
    logic [4:0]  fn;
    logic        op2;
    logic [2:0]  br;
    logic [31:0] imm;
    logic        ill;
  } vec_t;

  vec_t vecs [$];
  logic rdy_m, vld_m;
  logic [GW-1:0] exp_g;

  initial begin
    vecs.push_back('{"addi",   UOP_ADDI,  IMM_I, 20'hFFFFF, ALU_ADD, 1'b1, BR_NONE, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{"lui",    UOP_LUI,   IMM_U, 20'h12345, ALU_ADD, 1'b1, BR_NONE, 32'h12345000, 1'b0});
    vecs.push_back('{"beq",    UOP_BEQ,   IMM_B, 20'h00200, ALU_ADD, 1'b1, BR_BEQ,  32'h00000002, 1'b0});
    vecs.push_back('{"sub",    UOP_SUB,   IMM_I, 20'h00000, ALU_SUB, 1'b0, BR_NONE, 32'h00000000, 1'b0});
    vecs.push_back('{"auipc",  UOP_AUIPC, IMM_U, 20'h00001, ALU_ADD, 1'b1, BR_NONE, 32'h00001000, 1'b0});
    vecs.push_back('{"jalr",   UOP_JALR,  IMM_I, 20'h00800, ALU_ADD, 1'b1, BR_JAL,  32'h00000008, 1'b0});
    vecs.push_back('{"slli",   UOP_SLLI,  IMM_I, 20'h00500, ALU_SLL, 1'b1, BR_NONE, 32'h00000005, 1'b0});
    vecs.push_back('{"bne_j",  UOP_BNE,   IMM_J, 20'h80000, ALU_ADD, 1'b1, BR_BNE,  32'hFFF00000, 1'b0});
    vecs.push_back('{"unk50",  6'd50,     IMM_I, 20'h00000, ALU_ADD, 1'b1, BR_NONE, 32'h00000000, 1'b1});
    vecs.push_back('{"cbsxt3", UOP_CBSXT, IMM_I, 20'h00300, ALU_ADD, 1'b1, BR_NONE, 32'h00000003, 1'b1});
`ifdef EXE_DEC_BITMANIP_EN
    vecs.push_back('{"cbsxt2", UOP_CBSXT, IMM_I, 20'h00200, ALU_CPOP, 1'b1, BR_NONE, 32'h00000002, 1'b0});
    vecs.push_back('{"min",    UOP_MIN,   IMM_I, 20'h00000, ALU_MIN,  1'b0, BR_NONE, 32'h00000000, 1'b0});
`else
    vecs.push_back('{"cbsxt2", UOP_CBSXT, IMM_I, 20'h00200, ALU_ADD,  1'b1, BR_NONE, 32'h00000002, 1'b1});
    vecs.push_back('{"min",    UOP_MIN,   IMM_I, 20'h00000, ALU_ADD,  1'b1, BR_NONE, 32'h00000000, 1'b1});
`endif

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_lane_vld = '0; in_uopcode = '0; in_packed_imm = '0; in_imm_type = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_lane_vld", out_lane_vld, '0);
    check("rst_illegal", out_illegal, '0);
    check("rst_data", act_group(), '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // directed decode table, lane 0 only
    foreach (vecs[k]) begin
      in_valid = 1'b1; out_ready = 1'b1; in_lane_vld = 4'b0001;
      in_uopcode[0] = vecs[k].uop; in_imm_type[0] = vecs[k].it;
      in_packed_imm[0] = vecs[k].p; in_tag[0] = 6'(k);
      step();
      check({vecs[k].name, "_valid"}, out_valid, 1'b1);
      check(vecs[k].name, {out_alu_ctrl[0], out_brfn[0], out_imm[0], out_illegal[0]},
            {vecs[k].fn, vecs[k].op2, vecs[k].br, vecs[k].imm, vecs[k].ill});
    end

    // partially occupied group: empty lanes never flag illegal
    in_lane_vld = 4'b0101;
    for (int l = 0; l < LANES; l++) in_uopcode[l] = 6'd50;
    step();
    check("mask_lane_vld", out_lane_vld, 4'b0101);
    check("mask_illegal", out_illegal, 4'b0101);

    // backpressure: two accepted, third stalled, then in-order drain
    in_valid = 1'b0;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_lane_vld = 4'b0001; in_uopcode = '0;
    in_tag[0] = 6'd1;
    step();
    check("bp_ready_a", in_ready, 1'b1);
    check("bp_tag_a", out_tag[0], 6'd1);
    in_tag[0] = 6'd2;
    step();
    check("bp_ready_full", in_ready, 1'b0);
    in_tag[0] = 6'd3;
    step();
    check("bp_ready_hold", in_ready, 1'b0);
    check("bp_tag_stable", out_tag[0], 6'd1);
    out_ready = 1'b1;
    step();
    check("bp_tag_b", out_tag[0], 6'd2);
    check("bp_ready_reopen", in_ready, 1'b1);
    step();
    check("bp_tag_c", out_tag[0], 6'd3);
    in_valid = 1'b0;
    step();
    check("bp_drained", out_valid, 1'b0);

    // flush while full with an input offered
    out_ready = 1'b0; in_valid = 1'b1; in_tag[0] = 6'd4;
    step();
    in_tag[0] = 6'd5;
    step();
    check("fl_full", in_ready, 1'b0);
    in_tag[0] = 6'd6; flush = 1'b1;
    step();
    check("fl_out_valid", out_valid, 1'b0);
    check("fl_in_ready", in_ready, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("fl_no_ghost", out_valid, 1'b0);
    end

    // asynchronous reset with both entries full
    out_ready = 1'b0; in_valid = 1'b1;
    step();
    step();
    check("ar_full", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // randomized traffic against a queue reference
    for (int c = 0; c < 800; c++) begin
      check("rnd_valid", out_valid, q_exp.size() > 0);
      check("rnd_ready", in_ready, q_exp.size() < 2);
      if (q_exp.size() > 0) check("rnd_data", act_group(), q_exp[0]);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_lane_vld = 4'($urandom);
      for (int l = 0; l < LANES; l++) begin
        in_uopcode[l]    = 6'($urandom_range(0, 63));
        in_imm_type[l]   = 3'($urandom_range(0, 4));
        in_packed_imm[l] = 20'($urandom);
        in_tag[l]        = 6'($urandom);
      end
      rdy_m = (q_exp.size() < 2);
      vld_m = (q_exp.size() > 0);
      exp_g = m_group();
      step();
      if (flush) q_exp.delete();
      else begin
        if (vld_m && out_ready) void'(q_exp.pop_front());
        if (in_valid && rdy_m) q_exp.push_back(exp_g);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
